instr_fetch_unit: RTL and testbench

Instruction fetch stage between `program_counter` and instruction memory. Each fetch latches the PC word address and issues a request/acknowledge read to instruction memory. It holds the returned word for decode under a valid/ready handshake, then pulses `pc_advance`. It also decodes `beq` (opcode `6'b000100`) and drives the `branch` request and sign-extended `address` offset back to the PC.

---
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read channel plus the valid/ready
// handshake that hands fetched words to decode.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one-outstanding-request instruction fetch stage.
// IDLE latches the PC and raises the memory request, WAIT collects the
// acknowledged word, HOLD presents it to decode until accepted, then the PC
// is told to advance. beq (opcode 6'b000100) is decoded into a branch
// request with a sign-extended 16-bit offset during the handshake cycle.
// Optional feature: define FETCH_TIMEOUT_EN to abort a request that gets no
// mem_ack within TIMEOUT WAIT cycles (returns a NOP and pulses fetch_err).
module instr_fetch_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_in,
    instr_fetch_unit_if.master        bus,
    output logic                      pc_advance,
    output logic                      branch,
    output logic [31:0]               address,
    output logic                      fetch_err
);

    localparam logic [5:0] OPC_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        handshake;

`ifdef FETCH_TIMEOUT_EN
    // Counter value seen in the last WAIT cycle before the abort fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       fetch_err_q, fetch_err_d;
`else
    localparam int timeout_unused = TIMEOUT;
`endif

    assign handshake = instr_valid_q & bus.instr_ready;

    // Next-state and register-update decode for the three-state fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
        fetch_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_addr_d = pc_in;
                mem_req_d  = 1'b1;
                state_d    = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                cnt_d      = 8'd0;
`endif
            end
            ST_WAIT: begin
                // An ack in the same cycle as the timeout takes priority.
                if (bus.mem_ack) begin
                    instr_d       = bus.mem_rdata;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    instr_d       = 32'h0000_0000;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                    cnt_d         = cnt_q + 8'd1;
                    state_d       = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_HOLD: begin
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter and one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;

    // Handshake-cycle outputs back to the PC.
    assign pc_advance = handshake;
    assign branch     = handshake & (instr_q[31:26] == OPC_BEQ);
    assign address    = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: bench-driven memory and decode,
// expected words queued when the ack is driven and compared at handshake.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        branch;
    logic [31:0] address;
    logic        fetch_err;

    instr_fetch_unit_if ifu_bus ();

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .bus        (ifu_bus),
        .pc_advance (pc_advance),
        .branch     (branch),
        .address    (address),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] word);
        exp_t e;
        e.instr = word;
        e.br    = (word[31:26] == 6'b000100);
        e.addr  = {{16{word[15]}}, word[15:0]};
        sb_q.push_back(e);
    endtask

    // Compare the word offered in the current handshake cycle.
    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("hs_instr", ifu_bus.instr, e.instr);
            check("hs_branch", branch, e.br);
            if (e.br) check("hs_address", address, e.addr);
        end
    endtask

    // From IDLE: present pc, expect the request one cycle later.
    task automatic start_fetch(input logic [31:0] pc);
        pc_in = pc;
        ifu_bus.mem_ack = 1'b0;
        step();
        check("req_after_idle", ifu_bus.mem_req, 1'b1);
        check("req_addr", ifu_bus.mem_addr, pc);
        pc_in = pc + 32'h100;  // must not affect the latched address
    endtask

    // From the first WAIT cycle: ack after ack_delay cycles, accept after ready_delay.
    task automatic finish_fetch(input logic [31:0] pc, input logic [31:0] word,
                                input int ack_delay, input int ready_delay);
        ifu_bus.instr_ready = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
            ifu_bus.mem_rdata = $urandom;
            step();
        end
        check("wait_req_held", ifu_bus.mem_req, 1'b1);
        check("wait_addr_stable", ifu_bus.mem_addr, pc);
        check("wait_no_valid", ifu_bus.instr_valid, 1'b0);
        ifu_bus.mem_ack   = 1'b1;
        ifu_bus.mem_rdata = word;
        sb_push(word);
        step();
        ifu_bus.mem_ack   = 1'b0;
        ifu_bus.mem_rdata = $urandom;
        check("valid_after_ack", ifu_bus.instr_valid, 1'b1);
        check("req_dropped", ifu_bus.mem_req, 1'b0);
        for (int i = 0; i < ready_delay; i++) begin
            ifu_bus.mem_rdata = $urandom;
            step();
            check("hold_instr", ifu_bus.instr, word);
            check("hold_valid", ifu_bus.instr_valid, 1'b1);
            check("hold_no_adv", pc_advance, 1'b0);
            check("hold_no_branch", branch, 1'b0);
        end
        ifu_bus.instr_ready = 1'b1;
        #1;
        check("hs_pc_advance", pc_advance, 1'b1);
        sb_compare();
        step();
        ifu_bus.instr_ready = 1'b0;
        check("post_hs_valid", ifu_bus.instr_valid, 1'b0);
        check("post_hs_adv", pc_advance, 1'b0);
        check("post_hs_branch", branch, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tp_words[4];
        int          adv_cyc[$];
        logic [31:0] req_addrs[$];
        logic        bump_pc;

        tp_words[0] = 32'h2008_0001;
        tp_words[1] = 32'h1109_0003;
        tp_words[2] = 32'h2008_0002;
        tp_words[3] = 32'h0000_0000;

        pc_in               = 32'h0000_0000;
        ifu_bus.mem_ack     = 1'b0;
        ifu_bus.mem_rdata   = 32'h0000_0000;
        ifu_bus.instr_ready = 1'b1;
        rst                 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state (instr_ready high so a bad valid would show on pc_advance).
        check("rst_mem_req", ifu_bus.mem_req, 1'b0);
        check("rst_mem_addr", ifu_bus.mem_addr, 32'h0);
        check("rst_instr_valid", ifu_bus.instr_valid, 1'b0);
        check("rst_instr", ifu_bus.instr, 32'h0);
        check("rst_pc_advance", pc_advance, 1'b0);
        check("rst_branch", branch, 1'b0);
        check("rst_fetch_err", fetch_err, 1'b0);
        rst = 1'b0;
        ifu_bus.instr_ready = 1'b0;

        // Basic fetch, ack one cycle after request.
        start_fetch(32'h0);
        finish_fetch(32'h0, 32'h2008_0005, 1, 0);

        // Decode stalls for 5 cycles while memory data keeps changing.
        start_fetch(32'h1);
        finish_fetch(32'h1, 32'h2009_0007, 0, 5);

        // beq with positive and negative offsets.
        start_fetch(32'h2);
        finish_fetch(32'h2, 32'h1109_000A, 0, 2);
        start_fetch(32'h3);
        finish_fetch(32'h3, 32'h1109_FFFE, 2, 0);

        // Reset during WAIT, late ack afterwards.
        start_fetch(32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", ifu_bus.mem_req, 1'b0);
        check("rst_mid_no_valid", ifu_bus.instr_valid, 1'b0);
        ifu_bus.mem_ack   = 1'b1;
        ifu_bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        pc_in = 32'h40;
        rst   = 1'b0;
        step();
        ifu_bus.mem_ack = 1'b0;
        check("post_rst_req", ifu_bus.mem_req, 1'b1);
        check("post_rst_addr", ifu_bus.mem_addr, 32'h40);
        check("post_rst_no_valid", ifu_bus.instr_valid, 1'b0);
        finish_fetch(32'h40, 32'h8C08_0004, 0, 0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: abort after TIMEOUT WAIT cycles, then a late ack.
        start_fetch(32'h8);
        ifu_bus.mem_rdata = 32'hCAFE_F00D;
        repeat (14) step();
        check("to_no_err_early", fetch_err, 1'b0);
        check("to_req_early", ifu_bus.mem_req, 1'b1);
        step();
        check("to_fetch_err", fetch_err, 1'b1);
        check("to_instr_nop", ifu_bus.instr, 32'h0);
        check("to_valid", ifu_bus.instr_valid, 1'b1);
        check("to_req_drop", ifu_bus.mem_req, 1'b0);
        ifu_bus.mem_ack = 1'b1;
        step();
        ifu_bus.mem_ack = 1'b0;
        check("to_err_pulse_end", fetch_err, 1'b0);
        check("to_late_ack_instr", ifu_bus.instr, 32'h0);
        check("to_late_ack_valid", ifu_bus.instr_valid, 1'b1);
        ifu_bus.instr_ready = 1'b1;
        #1;
        check("to_hs_adv", pc_advance, 1'b1);
        step();
        ifu_bus.instr_ready = 1'b0;
        check("to_post_valid", ifu_bus.instr_valid, 1'b0);
`else
        // No ack for a long time: request simply stays pending.
        start_fetch(32'h8);
        repeat (20) step();
        check("long_wait_req", ifu_bus.mem_req, 1'b1);
        check("long_wait_no_valid", ifu_bus.instr_valid, 1'b0);
        check("long_wait_no_err", fetch_err, 1'b0);
        finish_fetch(32'h8, 32'h2008_0009, 0, 0);
`endif

        // Back-to-back, zero-wait memory, decode always ready.
        ifu_bus.instr_ready = 1'b1;
        pc_in   = 32'h0;
        bump_pc = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (bump_pc) pc_in = pc_in + 32'h1;
            bump_pc = 1'b0;
            if (ifu_bus.mem_req) begin
                ifu_bus.mem_ack   = 1'b1;
                ifu_bus.mem_rdata = tp_words[ifu_bus.mem_addr[1:0]];
                req_addrs.push_back(ifu_bus.mem_addr);
                sb_push(tp_words[ifu_bus.mem_addr[1:0]]);
            end else begin
                ifu_bus.mem_ack   = 1'b0;
                ifu_bus.mem_rdata = $urandom;
            end
            #1;
            if (pc_advance) begin
                adv_cyc.push_back(c);
                sb_compare();
                bump_pc = 1'b1;
            end
            step();
        end
        ifu_bus.mem_ack     = 1'b0;
        ifu_bus.instr_ready = 1'b0;
        check("tp_req_count", req_addrs.size(), 32'd3);
        check("tp_adv_count", adv_cyc.size(), 32'd3);
        if (req_addrs.size() == 3) begin
            for (int i = 0; i < 3; i++) check("tp_mem_addr", req_addrs[i], 32'(i));
        end
        if (adv_cyc.size() == 3) begin
            check("tp_first_adv", adv_cyc[0], 32'd2);
            check("tp_adv_gap1", adv_cyc[1] - adv_cyc[0], 32'd3);
            check("tp_adv_gap2", adv_cyc[2] - adv_cyc[1], 32'd3);
        end

        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
